// File: rtl/seq_det_event_logger.sv
// Timestamps each detection pulse from the 101 sequence detector and queues the timestamps in a
// small first-word-fall-through FIFO, alongside a saturating detection count and a sticky overflow.
module seq_det_event_logger #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det_in,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [TS_W-1:0]          rd_ts,
    output logic [CNT_W-1:0]         det_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic [TS_W-1:0]  mem [DEPTH];

    logic det_event, full, empty, pop, push, drop;

    always_comb begin
        det_event = en & det_in;
        full      = (level_q == LW'(DEPTH));
        empty     = (level_q == '0);
        pop       = ~empty & rd_ready;
        // A full FIFO can still accept the new entry when the head leaves in the same cycle.
        push      = det_event & (~full | pop);
        drop      = det_event & full & ~pop;
    end

    always_comb begin
        ts_d     = ts_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (clr) begin
            ts_d     = '0;
            cnt_d    = '0;
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (en) ts_d = ts_q + TS_W'(1);
            if (det_event && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q     <= '0;
            cnt_q    <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only read while the level says they are valid.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr_q] <= ts_q;
    end

    always_comb begin
        rd_valid   = ~empty;
        rd_ts      = empty ? '0 : mem[rd_ptr_q];
        det_count  = cnt_q;
        fifo_level = level_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_seq_det_event_logger.sv
// Directed and randomized checks of seq_det_event_logger against a queue-based reference model.
module tb_seq_det_event_logger;

    localparam int unsigned TS_W  = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;

    logic                   clk, rst, det_in, en, clr, rd_ready;
    logic                   rd_valid, overflow;
    logic [TS_W-1:0]        rd_ts;
    logic [CNT_W-1:0]       det_count;
    logic [$clog2(DEPTH):0] fifo_level;

    seq_det_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .det_in     (det_in),
        .en         (en),
        .clr        (clr),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_ts      (rd_ts),
        .det_count  (det_count),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_ts;
    int unsigned m_cnt;
    bit          m_ovf;
    int unsigned m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ts  = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit d, input bit e, input bit c, input bit r);
        if (c) begin
            model_reset();
        end else begin
            if (e && d && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (r && m_q.size() != 0) void'(m_q.pop_front());
            if (e && d) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ts);
                else m_ovf = 1;
            end
            if (e) m_ts = (m_ts + 1) % (1 << TS_W);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
        chk({tag, "_ts"}, 32'(rd_ts), (m_q.size() != 0) ? m_q[0] : 0);
        chk({tag, "_count"}, 32'(det_count), m_cnt);
        chk({tag, "_level"}, 32'(fifo_level), m_q.size());
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input bit d, input bit e, input bit c, input bit r, input string tag);
        det_in   = d;
        en       = e;
        clr      = c;
        rd_ready = r;
        @(posedge clk);
        model_edge(d, e, c, r);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; det_in = 1'b0; en = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b1;

        // Detector stream x=1,0,1,0,1 produces det_in at ts 2 and 4
        step(0, 1, 0, 0, "int");
        step(0, 1, 0, 0, "int");
        step(1, 1, 0, 0, "int");
        step(0, 1, 0, 0, "int");
        step(1, 1, 0, 0, "int");
        chk("int_count", 32'(det_count), 2);
        chk("int_level", 32'(fifo_level), 2);
        chk("int_head0", 32'(rd_ts), 2);
        step(0, 1, 0, 1, "int_pop");
        chk("int_head1", 32'(rd_ts), 4);
        step(0, 1, 0, 1, "int_pop");
        chk("int_empty", 32'(rd_valid), 0);

        // Overflow: six events into a four-deep FIFO with no reader
        step(0, 0, 1, 0, "clr");
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0, "ovf");
            if (i == 4) begin
                chk("ovf_level5", 32'(fifo_level), 4);
                chk("ovf_flag5", 32'(overflow), 1);
            end
        end
        chk("ovf_count", 32'(det_count), 6);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", 32'(rd_ts), i);
            step(0, 0, 0, 1, "ovf_pop");
        end

        // Full FIFO with a push and pop on the same edge
        step(0, 0, 1, 0, "clr");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, "fp_idle");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, "fp_fill");
        step(1, 1, 0, 1, "fp_swap");
        chk("fp_ovf", 32'(overflow), 0);
        chk("fp_level", 32'(fifo_level), 4);
        for (int i = 0; i < 4; i++) begin
            chk("fp_order", 32'(rd_ts), 11 + i);
            step(0, 0, 0, 1, "fp_pop");
        end

        // Disabled logging ignores det_in
        begin
            int unsigned cnt_before;
            cnt_before = m_cnt;
            for (int i = 0; i < 5; i++) step(1, 0, 0, 0, "en_off");
            chk("en_count", 32'(det_count), cnt_before);
        end
        step(0, 0, 1, 0, "clr");
        for (int i = 0; i < 300; i++) step(1, 1, 0, 1, "sat");
        chk("sat_count", 32'(det_count), 255);
        chk("sat_ovf", 32'(overflow), 0);

        // clr wins over a same-cycle event and pop
        step(0, 0, 1, 0, "clr");
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, "cp_fill");
        step(0, 1, 0, 1, "cp_pop");
        chk("cp_level3", 32'(fifo_level), 3);
        chk("cp_ovf1", 32'(overflow), 1);
        step(1, 1, 1, 1, "cp_clr");
        chk("cp_zero_level", 32'(fifo_level), 0);
        chk("cp_zero_cnt", 32'(det_count), 0);
        step(1, 1, 0, 0, "cp_next");
        chk("cp_next_ts", 32'(rd_ts), 0);

        // Asynchronous reset between clock edges
        step(0, 0, 1, 0, "clr");
        step(1, 1, 0, 0, "ar_fill");
        step(1, 1, 0, 0, "ar_fill");
        chk("ar_level2", 32'(fifo_level), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(rd_valid), 0);
        chk("ar_count", 32'(det_count), 0);
        chk("ar_level", 32'(fifo_level), 0);
        model_reset();
        #3;
        rst = 1'b1;
        step(1, 1, 0, 0, "ar_push");
        chk("ar_first_ts", 32'(rd_ts), 0);
        chk("ar_first_valid", 32'(rd_valid), 1);

        // Randomized traffic, reader bias changed halfway through
        for (int i = 0; i < 600; i++) begin
            bit d, e, c, r;
            d = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 63) == 0);
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(d, e, c, r, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
